uart_hex_dump_tx: RTL

Reads a byte range from the page buffer and transmits it over the UART TX path as ASCII hex lines. It is the readback counterpart of the UART receive and buffer-write path, used after FlashRdPg to show page contents on the terminal. The macro sequencer starts it with a start/done handshake. It shares the UART transmitter through the o_Tx_DV / i_Tx_Active / i_Tx_Done handshake.

---
 rtl/uart_pkg.sv | 43 ++++
 rtl/uart_char_sender.sv | 73 +++++++
 rtl/uart_hex_dump_tx.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_pkg
// Summary  : ASCII constants, FSM encodings and nibble-to-hex helper shared
//            by the UART hex dump transmit path.
// Revision : 1.0 - initial release
// ============================================================================
package uart_pkg;

  localparam logic [7:0] c_cr      = 8'h0D;
  localparam logic [7:0] c_lf      = 8'h0A;
  localparam logic [7:0] c_space   = 8'h20;
  localparam logic [7:0] c_colon   = 8'h3A;
  localparam logic [7:0] c_ascii_0 = 8'h30;
  localparam logic [7:0] c_ascii_a = 8'h41;

  typedef enum logic [3:0] {
    ST_IDLE    = 4'd0,
    ST_PFX     = 4'd1,
    ST_RD_REQ  = 4'd2,
    ST_RD_WAIT = 4'd3,
    ST_HI      = 4'd4,
    ST_LO      = 4'd5,
    ST_SEP     = 4'd6,
    ST_CR      = 4'd7,
    ST_LF      = 4'd8,
    ST_FIN     = 4'd9
  } dump_state_t;

  typedef enum logic [1:0] {
    SND_IDLE  = 2'd0,
    SND_DV    = 2'd1,
    SND_GUARD = 2'd2,
    SND_WAIT  = 2'd3
  } snd_state_t;

  function automatic logic [7:0] hex_to_ascii(input logic [3:0] nib);
    if (nib < 4'd10) return c_ascii_0 + {4'h0, nib};
    else             return c_ascii_a + {4'h0, nib - 4'd10};
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_char_sender.sv
`default_nettype none
// ============================================================================
// Module   : uart_char_sender
// Summary  : One-character send slot on the shared UART transmitter:
//            DV pulse, guard cycle, then wait for Active low and Done high.
// Revision : 1.0 - initial release
// ============================================================================
module uart_char_sender
  import uart_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       char_valid,
  input  logic [7:0] char_byte,
  output logic       char_ready,
  output logic       o_Tx_DV,
  output logic [7:0] o_Tx_Byte,
  input  logic       i_Tx_Active,
  input  logic       i_Tx_Done
);

  snd_state_t r_state, w_state_nxt;
  logic [7:0] r_byte, w_byte_nxt;
  logic       w_tx_free;

  assign w_tx_free = !i_Tx_Active && i_Tx_Done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= SND_IDLE;
      r_byte  <= 8'h00;
    end else begin
      r_state <= w_state_nxt;
      r_byte  <= w_byte_nxt;
    end
  end

  // Ready may rise in the same cycle as the qualifying Done so the next DV
  // lands in the cycle right after it.
  always_comb begin
    w_state_nxt = r_state;
    w_byte_nxt  = r_byte;
    char_ready  = 1'b0;
    case (r_state)
      SND_IDLE: begin
        char_ready = 1'b1;
        if (char_valid) begin
          w_byte_nxt  = char_byte;
          w_state_nxt = SND_DV;
        end
      end
      SND_DV:    w_state_nxt = SND_GUARD;
      SND_GUARD: w_state_nxt = SND_WAIT;
      SND_WAIT: begin
        if (w_tx_free) begin
          char_ready = 1'b1;
          if (char_valid) begin
            w_byte_nxt  = char_byte;
            w_state_nxt = SND_DV;
          end else begin
            w_state_nxt = SND_IDLE;
          end
        end
      end
      default: w_state_nxt = SND_IDLE;
    endcase
  end

  assign o_Tx_DV   = (r_state == SND_DV);
  assign o_Tx_Byte = r_byte;

endmodule
`default_nettype wire

// File: rtl/uart_hex_dump_tx.sv
`default_nettype none
// ============================================================================
// Module   : uart_hex_dump_tx
// Summary  : Reads a page-buffer byte range and prints it as ASCII hex lines
//            ("AAAA: xx xx ..\r\n") over the shared UART transmitter.
// Revision : 1.0 - initial release
// ============================================================================
module uart_hex_dump_tx
  import uart_pkg::*;
#(
  parameter int ADDR_W         = 16,
  parameter int BYTES_PER_LINE = 16,
  parameter int RD_LATENCY     = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W-1:0] byte_len,
  output logic              busy,
  output logic              done,
  output logic              buff_rden,
  output logic [ADDR_W-1:0] buff_rdaddr,
  input  logic [7:0]        buff_rddata,
  output logic              o_Tx_DV,
  output logic [7:0]        o_Tx_Byte,
  input  logic              i_Tx_Active,
  input  logic              i_Tx_Done
);

  localparam int               NDIG        = ADDR_W / 4;
  localparam int               PFX_W       = $clog2(NDIG + 2);
  localparam logic [PFX_W-1:0] c_pfx_colon = PFX_W'(NDIG);
  localparam logic [PFX_W-1:0] c_pfx_space = PFX_W'(NDIG + 1);
  localparam logic [7:0]       c_bpl       = 8'(BYTES_PER_LINE);
  localparam logic [1:0]       c_rd_lat    = 2'(RD_LATENCY);

  dump_state_t       r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_addr, w_addr_nxt;
  logic [ADDR_W-1:0] r_remain, w_remain_nxt;
  logic [ADDR_W-1:0] r_pfx_sh, w_pfx_sh_nxt;
  logic [PFX_W-1:0]  r_pfx_idx, w_pfx_idx_nxt;
  logic [7:0]        r_line_left, w_line_left_nxt;
  logic [7:0]        r_data, w_data_nxt;
  logic [1:0]        r_wait_cnt, w_wait_cnt_nxt;
  logic              r_busy, w_busy_nxt;
  logic              r_done, w_done_nxt;
  logic              w_char_valid, w_char_ready;
  logic [7:0]        w_char_byte;

  uart_char_sender u_sender (
    .clk         (clk),
    .rst_n       (rst_n),
    .char_valid  (w_char_valid),
    .char_byte   (w_char_byte),
    .char_ready  (w_char_ready),
    .o_Tx_DV     (o_Tx_DV),
    .o_Tx_Byte   (o_Tx_Byte),
    .i_Tx_Active (i_Tx_Active),
    .i_Tx_Done   (i_Tx_Done)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_addr      <= '0;
      r_remain    <= '0;
      r_pfx_sh    <= '0;
      r_pfx_idx   <= '0;
      r_line_left <= 8'h00;
      r_data      <= 8'h00;
      r_wait_cnt  <= 2'd0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_addr      <= w_addr_nxt;
      r_remain    <= w_remain_nxt;
      r_pfx_sh    <= w_pfx_sh_nxt;
      r_pfx_idx   <= w_pfx_idx_nxt;
      r_line_left <= w_line_left_nxt;
      r_data      <= w_data_nxt;
      r_wait_cnt  <= w_wait_cnt_nxt;
      r_busy      <= w_busy_nxt;
      r_done      <= w_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_addr_nxt      = r_addr;
    w_remain_nxt    = r_remain;
    w_pfx_sh_nxt    = r_pfx_sh;
    w_pfx_idx_nxt   = r_pfx_idx;
    w_line_left_nxt = r_line_left;
    w_data_nxt      = r_data;
    w_wait_cnt_nxt  = r_wait_cnt;
    w_busy_nxt      = r_busy;
    w_done_nxt      = 1'b0;
    w_char_valid    = 1'b0;
    w_char_byte     = c_space;
    case (r_state)
      ST_IDLE: begin
        // A start landing on the done cycle must not retrigger.
        if (start && !r_done) begin
          w_addr_nxt      = start_addr;
          w_remain_nxt    = byte_len;
          w_pfx_sh_nxt    = start_addr;
          w_pfx_idx_nxt   = '0;
          w_line_left_nxt = c_bpl;
          w_busy_nxt      = 1'b1;
          w_state_nxt     = (byte_len != '0) ? ST_PFX : ST_FIN;
        end
      end
      ST_PFX: begin
        w_char_valid = 1'b1;
        if (r_pfx_idx < c_pfx_colon)       w_char_byte = hex_to_ascii(r_pfx_sh[ADDR_W-1 -: 4]);
        else if (r_pfx_idx == c_pfx_colon) w_char_byte = c_colon;
        else                               w_char_byte = c_space;
        if (w_char_ready) begin
          if (r_pfx_idx == c_pfx_space) begin
            w_state_nxt = ST_RD_REQ;
          end else begin
            w_pfx_idx_nxt = r_pfx_idx + 1'b1;
            w_pfx_sh_nxt  = r_pfx_sh << 4;
          end
        end
      end
      ST_RD_REQ: begin
        w_wait_cnt_nxt = 2'd1;
        w_state_nxt    = ST_RD_WAIT;
      end
      ST_RD_WAIT: begin
        if (r_wait_cnt == c_rd_lat) begin
          w_data_nxt      = buff_rddata;
          w_addr_nxt      = r_addr + 1'b1;
          w_remain_nxt    = r_remain - 1'b1;
          w_line_left_nxt = r_line_left - 8'd1;
          w_state_nxt     = ST_HI;
        end else begin
          w_wait_cnt_nxt = r_wait_cnt + 2'd1;
        end
      end
      ST_HI: begin
        w_char_valid = 1'b1;
        w_char_byte  = hex_to_ascii(r_data[7:4]);
        if (w_char_ready) w_state_nxt = ST_LO;
      end
      ST_LO: begin
        w_char_valid = 1'b1;
        w_char_byte  = hex_to_ascii(r_data[3:0]);
        if (w_char_ready)
          w_state_nxt = (r_remain == '0 || r_line_left == 8'd0) ? ST_CR : ST_SEP;
      end
      ST_SEP: begin
        w_char_valid = 1'b1;
        w_char_byte  = c_space;
        if (w_char_ready) w_state_nxt = ST_RD_REQ;
      end
      ST_CR: begin
        w_char_valid = 1'b1;
        w_char_byte  = c_cr;
        if (w_char_ready) w_state_nxt = ST_LF;
      end
      ST_LF: begin
        w_char_valid = 1'b1;
        w_char_byte  = c_lf;
        if (w_char_ready) begin
          if (r_remain != '0) begin
            w_pfx_idx_nxt   = '0;
            w_pfx_sh_nxt    = r_addr;
            w_line_left_nxt = c_bpl;
            w_state_nxt     = ST_PFX;
          end else begin
            w_state_nxt = ST_FIN;
          end
        end
      end
      ST_FIN: begin
        // Hold completion until the final LF has left the transmitter.
        if (w_char_ready) begin
          w_done_nxt  = 1'b1;
          w_busy_nxt  = 1'b0;
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign busy        = r_busy;
  assign done        = r_done;
  assign buff_rden   = (r_state == ST_RD_REQ);
  assign buff_rdaddr = r_addr;

endmodule
`default_nettype wire
